// File: rtl/block_pkg.sv
// Shared encodings for the begin/end block stream emitter and its checker-side models.
// Holds command codes, the ASCII letters used by the keywords, and the emitter FSM states.
package block_pkg;

    localparam logic [1:0] CMD_BEGIN     = 2'd0;
    localparam logic [1:0] CMD_END       = 2'd1;
    localparam logic [1:0] CMD_IDENT     = 2'd2;
    localparam logic [1:0] CMD_CLOSE_ALL = 2'd3;

    localparam logic [7:0] CH_B     = 8'h62;
    localparam logic [7:0] CH_E     = 8'h65;
    localparam logic [7:0] CH_G     = 8'h67;
    localparam logic [7:0] CH_I     = 8'h69;
    localparam logic [7:0] CH_N     = 8'h6E;
    localparam logic [7:0] CH_D     = 8'h64;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TOKEN = 2'd1,
        SPACE = 2'd2
    } state_e;

endpackage

// File: rtl/block_token_rom.sv
// Maps (token, letter index) to the keyword byte and flags the final letter.
// CLOSE_ALL reuses the END spelling since it is emitted as repeated "end".
module block_token_rom
    import block_pkg::*;
(
    input  logic [1:0] tok_i,
    input  logic [2:0] idx_i,
    input  logic [7:0] char_i,
    output logic [7:0] byte_o,
    output logic       last_o
);

    always_comb begin
        byte_o = CH_SPACE;
        last_o = 1'b1;
        case (tok_i)
            CMD_BEGIN: begin
                last_o = 1'b0;
                case (idx_i)
                    3'd0:    byte_o = CH_B;
                    3'd1:    byte_o = CH_E;
                    3'd2:    byte_o = CH_G;
                    3'd3:    byte_o = CH_I;
                    3'd4: begin
                        byte_o = CH_N;
                        last_o = 1'b1;
                    end
                    default: last_o = 1'b1;
                endcase
            end
            CMD_END, CMD_CLOSE_ALL: begin
                last_o = 1'b0;
                case (idx_i)
                    3'd0:    byte_o = CH_E;
                    3'd1:    byte_o = CH_N;
                    3'd2: begin
                        byte_o = CH_D;
                        last_o = 1'b1;
                    end
                    default: last_o = 1'b1;
                endcase
            end
            default: begin
                byte_o = char_i;
                last_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/block_stream_emitter.sv
// Serialises BEGIN/END/IDENT/CLOSE_ALL commands into lowercase ASCII bytes,
// each token followed by a space, while tracking nesting depth and sticky error flags.
module block_stream_emitter
    import block_pkg::*;
#(
    parameter int MAX_DEPTH = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] cmd_char,
    output logic [7:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] depth,
    output logic       underflow,
    output logic       overflow,
    output logic       balanced
);

    localparam logic [7:0] MAX_D = 8'(MAX_DEPTH);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [1:0] tok_q, tok_d;
    logic [7:0] char_q, char_d;
    logic [7:0] rep_q, rep_d;
    logic [7:0] depth_q, depth_d;
    logic       underflow_q, underflow_d;
    logic       overflow_q, overflow_d;
    logic [7:0] out_q, out_d;
    logic       out_valid_q, out_valid_d;

    logic       hs;
    logic [7:0] cur_byte;
    logic       cur_last;
    logic [7:0] next_byte;
    logic       next_last;

    assign hs        = out_valid_q && out_ready;
    assign cmd_ready = (state_q == IDLE);
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign depth     = depth_q;
    assign underflow = underflow_q;
    assign overflow  = overflow_q;
    assign balanced  = (depth_q == 8'd0) && !underflow_q;

    // The current-position lookup decides when a token ends; the next-position
    // lookup preloads the output register so the byte appears one cycle after accept.
    block_token_rom u_rom_cur (
        .tok_i  (tok_q),
        .idx_i  (idx_q),
        .char_i (char_q),
        .byte_o (cur_byte),
        .last_o (cur_last)
    );

    block_token_rom u_rom_next (
        .tok_i  (tok_d),
        .idx_i  (idx_d),
        .char_i (char_d),
        .byte_o (next_byte),
        .last_o (next_last)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tok_d       = tok_q;
        char_d      = char_q;
        rep_d       = rep_q;
        depth_d     = depth_q;
        underflow_d = underflow_q;
        overflow_d  = overflow_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    idx_d = 3'd0;
                    rep_d = 8'd0;
                    tok_d = cmd;
                    case (cmd)
                        CMD_BEGIN: begin
                            state_d = TOKEN;
                            if (depth_q < MAX_D) depth_d = depth_q + 8'd1;
                            else                 overflow_d = 1'b1;
                        end
                        CMD_END: begin
                            state_d = TOKEN;
                            if (depth_q != 8'd0) depth_d = depth_q - 8'd1;
                            else                 underflow_d = 1'b1;
                        end
                        CMD_IDENT: begin
                            state_d = TOKEN;
                            char_d  = cmd_char;
                        end
                        default: begin
                            depth_d = 8'd0;
                            if (depth_q != 8'd0) begin
                                state_d = TOKEN;
                                rep_d   = depth_q - 8'd1;
                            end
                        end
                    endcase
                end
            end
            TOKEN: begin
                if (hs) begin
                    if (cur_last) state_d = SPACE;
                    else          idx_d   = idx_q + 3'd1;
                end
            end
            SPACE: begin
                if (hs) begin
                    if (rep_q != 8'd0) begin
                        rep_d   = rep_q - 8'd1;
                        idx_d   = 3'd0;
                        state_d = TOKEN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = (state_d != IDLE);
        case (state_d)
            TOKEN:   out_d = next_byte;
            SPACE:   out_d = CH_SPACE;
            default: out_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            tok_q       <= CMD_BEGIN;
            char_q      <= 8'h00;
            rep_q       <= 8'd0;
            depth_q     <= 8'd0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
            out_q       <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tok_q       <= tok_d;
            char_q      <= char_d;
            rep_q       <= rep_d;
            depth_q     <= depth_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Only the next-position byte is needed from the preload lookup.
    logic unused_next_last;
    assign unused_next_last = next_last;

endmodule

// File: tb/tb_block_stream_emitter.sv
// Scoreboard bench for block_stream_emitter: two instances (default depth and depth 2)
// with expected bytes queued at command issue and popped by per-instance monitors.
module tb_block_stream_emitter;
    import block_pkg::*;

    logic       clk;
    logic       rstN;
    logic [1:0] cmd;
    logic [7:0] cmdChar;
    logic       outReady;

    logic       cmdValidA, cmdReadyA, outValidA, underflowA, overflowA, balancedA;
    logic [7:0] outA, depthA;
    logic       cmdValidB, cmdReadyB, outValidB, underflowB, overflowB, balancedB;
    logic [7:0] outB, depthB;

    int checks;
    int errors;

    logic [7:0] expA[$];
    logic [7:0] expB[$];
    int         mDepth[2];
    logic       mUnder[2];
    logic       mOver[2];
    int         mMax[2];

    logic [7:0] kBegin[6];
    logic [7:0] kEnd[4];

    block_stream_emitter #(.MAX_DEPTH(15)) dutA (
        .clk(clk), .reset(rstN), .cmd_valid(cmdValidA), .cmd_ready(cmdReadyA),
        .cmd(cmd), .cmd_char(cmdChar), .out(outA), .out_valid(outValidA),
        .out_ready(outReady), .depth(depthA), .underflow(underflowA),
        .overflow(overflowA), .balanced(balancedA)
    );

    block_stream_emitter #(.MAX_DEPTH(2)) dutB (
        .clk(clk), .reset(rstN), .cmd_valid(cmdValidB), .cmd_ready(cmdReadyB),
        .cmd(cmd), .cmd_char(cmdChar), .out(outB), .out_valid(outValidB),
        .out_ready(outReady), .depth(depthB), .underflow(underflowB),
        .overflow(overflowB), .balanced(balancedB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor for instance A: every handshake must match the oldest queued byte.
    always @(negedge clk) begin
        if (rstN && outValidA && outReady) begin
            checks++;
            if (expA.size() == 0) begin
                errors++;
                $display("[TB] FAIL streamA: got byte %02h, expected no byte", outA);
            end else begin
                logic [7:0] e;
                e = expA.pop_front();
                if (outA !== e) begin
                    errors++;
                    $display("[TB] FAIL streamA: got %02h, expected %02h", outA, e);
                end
            end
        end
    end

    // Monitor for instance B, same rules as A.
    always @(negedge clk) begin
        if (rstN && outValidB && outReady) begin
            checks++;
            if (expB.size() == 0) begin
                errors++;
                $display("[TB] FAIL streamB: got byte %02h, expected no byte", outB);
            end else begin
                logic [7:0] e;
                e = expB.pop_front();
                if (outB !== e) begin
                    errors++;
                    $display("[TB] FAIL streamB: got %02h, expected %02h", outB, e);
                end
            end
        end
    end

    task automatic pushByte(input int which, input logic [7:0] b);
        if (which == 0) expA.push_back(b);
        else            expB.push_back(b);
    endtask

    task automatic modelCommand(input int which, input logic [1:0] c, input logic [7:0] ch);
        case (c)
            CMD_BEGIN: begin
                for (int i = 0; i < 6; i++) pushByte(which, kBegin[i]);
                if (mDepth[which] < mMax[which]) mDepth[which]++;
                else                             mOver[which] = 1'b1;
            end
            CMD_END: begin
                for (int i = 0; i < 4; i++) pushByte(which, kEnd[i]);
                if (mDepth[which] > 0) mDepth[which]--;
                else                   mUnder[which] = 1'b1;
            end
            CMD_IDENT: begin
                pushByte(which, ch);
                pushByte(which, 8'h20);
            end
            default: begin
                for (int r = 0; r < mDepth[which]; r++)
                    for (int i = 0; i < 4; i++) pushByte(which, kEnd[i]);
                mDepth[which] = 0;
            end
        endcase
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %02h, expected %02h", name, actual, expected);
        end
    endtask

    task automatic checkState(input int which, input string name);
        logic [7:0] d;
        logic u, o, b;
        d = (which == 0) ? depthA : depthB;
        u = (which == 0) ? underflowA : underflowB;
        o = (which == 0) ? overflowA : overflowB;
        b = (which == 0) ? balancedA : balancedB;
        checkOutput({name, ".depth"}, d, 8'(mDepth[which]));
        checkOutput({name, ".underflow"}, {7'd0, u}, {7'd0, mUnder[which]});
        checkOutput({name, ".overflow"}, {7'd0, o}, {7'd0, mOver[which]});
        checkOutput({name, ".balanced"}, {7'd0, b},
                    {7'd0, (mDepth[which] == 0) && !mUnder[which]});
    endtask

    // Waits (bounded) until the instance is idle and all its expected bytes were seen.
    task automatic waitIdle(input int which);
        for (int n = 0; n < 200; n++) begin
            logic rdy;
            int   qs;
            rdy = (which == 0) ? cmdReadyA : cmdReadyB;
            qs  = (which == 0) ? expA.size() : expB.size();
            if (rdy && qs == 0) return;
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("[TB] FAIL waitIdle%0d: timed out, ready=%0b pendingA=%0d pendingB=%0d",
                 which, (which == 0) ? cmdReadyA : cmdReadyB, expA.size(), expB.size());
    endtask

    // Issues one command when the instance is idle; returns 1ns after the accepting edge.
    task automatic applyStimulus(input int which, input logic [1:0] c, input logic [7:0] ch);
        waitIdle(which);
        modelCommand(which, c, ch);
        cmd     = c;
        cmdChar = ch;
        if (which == 0) cmdValidA = 1'b1;
        else            cmdValidB = 1'b1;
        @(posedge clk);
        #1;
        cmdValidA = 1'b0;
        cmdValidB = 1'b0;
    endtask

    task automatic resetModels();
        expA.delete();
        expB.delete();
        for (int w = 0; w < 2; w++) begin
            mDepth[w] = 0;
            mUnder[w] = 1'b0;
            mOver[w]  = 1'b0;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        kBegin = '{8'h62, 8'h65, 8'h67, 8'h69, 8'h6E, 8'h20};
        kEnd   = '{8'h65, 8'h6E, 8'h64, 8'h20};
        mMax[0] = 15;
        mMax[1] = 2;
        resetModels();
        rstN = 1'b0; outReady = 1'b1;
        cmd = CMD_BEGIN; cmdChar = 8'h00;
        cmdValidA = 1'b0; cmdValidB = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetOut", outA, 8'h00);
        checkOutput("resetOutValid", {7'd0, outValidA}, 8'h00);
        checkOutput("resetCmdReady", {7'd0, cmdReadyA}, 8'h01);
        checkState(0, "reset");
        rstN = 1'b1;
        @(posedge clk);
        #1;

        // Basic BEGIN with cycle-accurate first byte and return to idle.
        applyStimulus(0, CMD_BEGIN, 8'h00);
        checkOutput("beginFirstByte", outA, 8'h62);
        checkOutput("beginFirstValid", {7'd0, outValidA}, 8'h01);
        checkState(0, "afterBegin");
        repeat (5) @(posedge clk);
        #1;
        checkOutput("beginBusyAtN6", {7'd0, cmdReadyA}, 8'h00);
        @(posedge clk);
        #1;
        checkOutput("beginReadyAtN7", {7'd0, cmdReadyA}, 8'h01);
        checkOutput("beginIdleValid", {7'd0, outValidA}, 8'h00);
        applyStimulus(0, CMD_END, 8'h00);
        waitIdle(0);
        checkState(0, "beginEnd");

        // Nested close: "begin begin x end end " with no bubbles in the end run.
        applyStimulus(0, CMD_BEGIN, 8'h00);
        applyStimulus(0, CMD_BEGIN, 8'h00);
        applyStimulus(0, CMD_IDENT, 8'h78);
        applyStimulus(0, CMD_CLOSE_ALL, 8'h00);
        checkState(0, "closeAllDepth");
        for (int i = 0; i < 8; i++) begin
            checkOutput("closeAllNoGap", {7'd0, outValidA}, 8'h01);
            @(posedge clk);
            #1;
        end
        waitIdle(0);

        // IDENT of a space is sent verbatim.
        applyStimulus(0, CMD_IDENT, 8'h20);
        waitIdle(0);

        // Underflow is sticky and keeps balanced low.
        applyStimulus(0, CMD_END, 8'h00);
        waitIdle(0);
        checkState(0, "underflow");
        applyStimulus(0, CMD_BEGIN, 8'h00);
        applyStimulus(0, CMD_END, 8'h00);
        waitIdle(0);
        checkState(0, "underflowSticky");

        // Backpressure holds 'g' for three cycles.
        applyStimulus(0, CMD_BEGIN, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("stallByte", outA, 8'h67);
            checkOutput("stallValid", {7'd0, outValidA}, 8'h01);
        end
        outReady = 1'b1;
        waitIdle(0);

        // Asynchronous reset during the third byte of END.
        applyStimulus(0, CMD_BEGIN, 8'h00);
        applyStimulus(0, CMD_END, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("preResetByte", outA, 8'h64);
        #2;
        rstN = 1'b0;
        #1;
        resetModels();
        checkOutput("midResetOut", outA, 8'h00);
        checkOutput("midResetValid", {7'd0, outValidA}, 8'h00);
        checkOutput("midResetReady", {7'd0, cmdReadyA}, 8'h01);
        checkState(0, "midReset");
        @(posedge clk);
        #1;
        rstN = 1'b1;
        applyStimulus(0, CMD_BEGIN, 8'h00);
        checkOutput("postResetFirst", outA, 8'h62);
        waitIdle(0);
        checkState(0, "postReset");

        // Overflow on the depth-2 instance, then CLOSE_ALL emits exactly two "end ".
        applyStimulus(1, CMD_BEGIN, 8'h00);
        applyStimulus(1, CMD_BEGIN, 8'h00);
        applyStimulus(1, CMD_BEGIN, 8'h00);
        waitIdle(1);
        checkState(1, "overflow");
        applyStimulus(1, CMD_CLOSE_ALL, 8'h00);
        waitIdle(1);
        checkState(1, "overflowClosed");

        // CLOSE_ALL at depth 0 sends nothing and stays ready.
        applyStimulus(1, CMD_CLOSE_ALL, 8'h00);
        checkOutput("closeEmptyReady", {7'd0, cmdReadyB}, 8'h01);
        checkOutput("closeEmptyValid", {7'd0, outValidB}, 8'h00);
        repeat (2) @(posedge clk);
        #1;

        waitIdle(0);
        waitIdle(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/block_stream_emitter.md
# block_stream_emitter

Transmit-side companion to the begin/end block checker. Accepts token commands (BEGIN, END, single-character IDENT, CLOSE_ALL) and serialises each one as a lowercase ASCII byte stream, one byte per accepted beat, followed by a single space (0x20). The emitter tracks nesting depth and raises sticky flags on underflow and overflow. It drives checker-side stimulus and generates keyword streams for the text-processing path.

## Interface

- MAX_DEPTH, default 15: maximum tracked nesting depth, 1..255.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; the block is in reset while reset==0.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  emitter idle, can accept a command.
- cmd  in  2  0=BEGIN, 1=END, 2=IDENT, 3=CLOSE_ALL.
- cmd_char  in  8  byte emitted for IDENT; ignored for other commands.
- out  out  8  current output byte.
- out_valid  out  1  out holds a valid byte.
- out_ready  in  1  downstream accepts the byte this cycle.
- depth  out  8  current nesting depth.
- underflow  out  1  sticky: END issued at depth 0.
- overflow  out  1  sticky: BEGIN issued at depth MAX_DEPTH.
- balanced  out  1  depth==0 && !underflow, combinational from registers.

## Operation

- Reset values: out=0x00, out_valid=0, cmd_ready=1, depth=0, underflow=0, overflow=0, so balanced=1.
- A command is accepted when cmd_valid && cmd_ready. cmd_ready is 1 only in IDLE.
- Byte sequences:
  - BEGIN: "begin " (62 65 67 69 6E 20).
  - END: "end " (65 6E 64 20).
  - IDENT: cmd_char, then 20. cmd_char is sent verbatim, including 0x20.
  - CLOSE_ALL: "end " repeated depth times, using depth as sampled at acceptance. If depth is 0, no bytes are sent.
- Depth update at acceptance:
  - BEGIN: if depth<MAX_DEPTH, increment. Otherwise set overflow and hold depth; the token is still emitted.
  - END: if depth>0, decrement. Otherwise set underflow and hold depth; the token is still emitted.
  - CLOSE_ALL: depth set to 0. Underflow is not affected.
  - IDENT: no change.
- underflow and overflow clear only on reset.
- State machine:
  - IDLE → TOKEN on accept. CLOSE_ALL with depth 0 stays in IDLE, and cmd_ready stays 1.
  - TOKEN: advance the 3-bit char index on each out handshake. After the last letter → SPACE. IDENT has a one-byte token.
  - SPACE: on handshake, if CLOSE_ALL repeats remain, decrement the repeat counter and go to TOKEN with index 0. Otherwise go to IDLE.
- A byte handshake is out_valid && out_ready. While out_valid && !out_ready, out and out_valid hold stable.

## Timing

- Accept in cycle N: first byte is valid in cycle N+1, registered.
- With out_ready held at 1, one byte per cycle and no bubbles, including across CLOSE_ALL repetitions.
- The cycle after the final space handshake: out_valid=0, cmd_ready=1. A new command can be accepted in that cycle, so back-to-back commands have exactly one idle cycle between them.
- depth, underflow and overflow are visible in cycle N+1 after acceptance in cycle N.
- Reset asserted mid-stream:
  - All outputs return to their reset values immediately, asynchronously.
  - A partially sent token is abandoned.
  - Operation resumes on the first clock edge after reset rises.

## Structure

- Package block_pkg holds:
  - command encodings CMD_BEGIN, CMD_END, CMD_IDENT, CMD_CLOSE_ALL;
  - ASCII constants for b, e, g, i, n, d and space;
  - the state enum IDLE/TOKEN/SPACE.
- One sub-module, block_token_rom: combinational (token select, index) → byte, plus last-index flag. It is shared with the checker's bench model.
- The top level holds the FSM, char index, repeat counter, depth logic and output register.

## Test plan

- Basic BEGIN: reset, BEGIN, out_ready=1 → 62 65 67 69 6E 20 on cycles N+1..N+6; depth=1, balanced=0; cmd_ready=1 at N+7.
- Close all: BEGIN, BEGIN, IDENT 'x', CLOSE_ALL → the stream "begin begin x end end " with no gaps inside CLOSE_ALL; final depth=0, balanced=1.
- Underflow: END at depth 0 → 65 6E 64 20 emitted, underflow=1, balanced=0. A subsequent BEGIN then END keeps balanced=0 with depth=0.
- Backpressure: during BEGIN, drop out_ready for 3 cycles while out=67 → out stays 67 and out_valid stays 1; the stream resumes with 69 and no byte is lost or duplicated.
- Overflow: MAX_DEPTH=2, three BEGINs → overflow=1, depth=2, three "begin " tokens emitted. CLOSE_ALL then emits exactly two "end ".
- Reset mid-stream: assert reset during the third byte of END → out_valid=0, out=0x00, depth=0 and cmd_ready=1 before the next clock edge. The next BEGIN emits cleanly from 62.
